// File: rtl/mem_responder_if.sv
// Initiator-side bus and preload port of mem_responder, with initiator (master)
// and responder (slave) views.
interface mem_responder_if;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic       we;
  logic       mem_req;
  logic [7:0] data_out;
  logic       mem_ready;
  logic       load_we;
  logic [7:0] load_addr;
  logic [7:0] load_data;

  modport master (
    output addr, data_in, we, mem_req,
    output load_we, load_addr, load_data,
    input  data_out, mem_ready
  );

  modport slave (
    input  addr, data_in, we, mem_req,
    input  load_we, load_addr, load_data,
    output data_out, mem_ready
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: 256x8 request/ack memory with read-before-write and a side preload port.
// Wait states are built only when MEM_RESPONDER_WAIT_EN is defined (WAIT_CYCLES extra cycles).
module mem_responder #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_cycles_range
    $error("mem_responder: WAIT_CYCLES must be in 0..15");
  end

`ifdef MEM_RESPONDER_WAIT_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam int         WAIT_LAST_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0] WAIT_LAST   = 4'(WAIT_LAST_I);

  logic [3:0] r_wait_cnt;
`else
  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;
`endif

  state_t     r_state;
  state_t     w_state_next;

  logic [7:0] r_mem [0:255];

  logic [7:0] r_addr;
  logic       r_we;
  logic [7:0] r_wdata;
  logic [7:0] r_data_out;

  logic       w_mem_ready;
  logic       w_accept;
  logic       w_ack_entry;
  logic       w_wr_en;
  logic       w_load_en;
  logic [7:0] w_acc_addr;
  logic       w_acc_we;
  logic [7:0] w_acc_wdata;

  assign w_accept = (r_state == S_IDLE) && bus.mem_req && !w_mem_ready;

  // Going straight from IDLE to ACK, the request is not latched yet, so use the live bus.
  assign w_acc_addr  = (r_state == S_IDLE) ? bus.addr    : r_addr;
  assign w_acc_we    = (r_state == S_IDLE) ? bus.we      : r_we;
  assign w_acc_wdata = (r_state == S_IDLE) ? bus.data_in : r_wdata;

  assign w_ack_entry = (w_state_next == S_ACK) && (r_state != S_ACK);
  assign w_wr_en     = w_ack_entry && w_acc_we;
  assign w_load_en   = bus.load_we && !(w_wr_en && (bus.load_addr == w_acc_addr));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef MEM_RESPONDER_WAIT_EN
          w_state_next = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
`else
          w_state_next = S_ACK;
`endif
        end
      end
`ifdef MEM_RESPONDER_WAIT_EN
      S_WAIT: begin
        if (r_wait_cnt == WAIT_LAST) begin
          w_state_next = S_ACK;
        end
      end
`endif
      S_ACK: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    w_mem_ready = 1'b0;
    if (r_state == S_ACK) begin
      w_mem_ready = 1'b1;
    end
  end

`ifdef MEM_RESPONDER_WAIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 4'd0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= 8'h00;
      r_we       <= 1'b0;
      r_wdata    <= 8'h00;
      r_data_out <= 8'h00;
    end else begin
      if (w_accept) begin
        r_addr  <= bus.addr;
        r_we    <= bus.we;
        r_wdata <= bus.data_in;
      end
      if (w_ack_entry) begin
        r_data_out <= r_mem[w_acc_addr];
      end
    end
  end

  // Storage is never cleared; reset only blocks writes. Initiator write wins an address clash.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst) begin
      if (w_load_en) begin
        r_mem[bus.load_addr] <= bus.load_data;
      end
      if (w_wr_en) begin
        r_mem[w_acc_addr] <= w_acc_wdata;
      end
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.mem_ready = w_mem_ready;

endmodule
